// File: rtl/pe_pooling_pkg.sv
// Shared types and sizing helpers for the pooling control blocks.
package pe_pooling_pkg;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    SLIDE = 1'b1
  } pool_win_state_e;

  // Counter width for a modulus n; never returns zero so 1-value counters stay legal.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned POOL_ROW_LEN_DEF = 16;
  localparam int unsigned POOL_STRIDE_DEF  = 2;
  localparam int unsigned POOL_COL_W_DEF   = cnt_w(POOL_ROW_LEN_DEF);
  localparam int unsigned POOL_PHASE_W_DEF = cnt_w(POOL_STRIDE_DEF);

endpackage

// File: rtl/pe_pooling_window_gen.sv
// Serial-to-window front end: assembles strided 1-D windows of a row-major pixel stream.
module pe_pooling_window_gen
  import pe_pooling_pkg::*;
#(
  parameter int unsigned pDATA_WIDTH  = 8,
  parameter int unsigned pWINDOW_SIZE = 3,
  parameter int unsigned pSTRIDE      = 2,
  parameter int unsigned pROW_LEN     = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear,
  input  logic                                valid_in,
  input  logic [pDATA_WIDTH-1:0]              data_in,
  output logic                                valid_out,
  output logic [pDATA_WIDTH*pWINDOW_SIZE-1:0] data_out,
  output logic                                row_done
);

  if (pWINDOW_SIZE < 1 || pSTRIDE < 1 || pROW_LEN < pWINDOW_SIZE) begin : g_param_check
    $fatal(1, "pe_pooling_window_gen: illegal parameters (need N>=1, S>=1, L>=N)");
  end

  localparam int unsigned COL_W = cnt_w(pROW_LEN);
  localparam int unsigned PH_W  = cnt_w(pSTRIDE);

  localparam logic [COL_W-1:0] COL_LAST     = COL_W'(pROW_LEN - 1);
  localparam logic [COL_W-1:0] COL_FILL_END = COL_W'((pWINDOW_SIZE >= 2) ? pWINDOW_SIZE - 2 : 0);
  localparam logic [PH_W-1:0]  PH_LAST      = PH_W'(pSTRIDE - 1);
  localparam pool_win_state_e  START_STATE  = (pWINDOW_SIZE == 1) ? SLIDE : FILL;

  typedef logic [pWINDOW_SIZE-1:0][pDATA_WIDTH-1:0] win_t;

  pool_win_state_e  state, state_nxt;
  logic [COL_W-1:0] col, col_nxt;
  logic [PH_W-1:0]  phase, phase_nxt;
  win_t             sr, sr_nxt;
  logic             emit_c;
  logic             last_c;

  // Next-state: shift register, column/phase counters and FILL/SLIDE control.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    phase_nxt = phase;
    sr_nxt    = sr;
    emit_c    = 1'b0;
    last_c    = 1'b0;
    if (clear) begin
      state_nxt = START_STATE;
      col_nxt   = '0;
      phase_nxt = '0;
      sr_nxt    = '0;
    end else if (valid_in) begin
      for (int unsigned k = 0; k + 1 < pWINDOW_SIZE; k++) begin
        sr_nxt[k] = sr[k+1];
      end
      sr_nxt[pWINDOW_SIZE-1] = data_in;
      last_c  = (col == COL_LAST);
      col_nxt = last_c ? '0 : col + COL_W'(1);
      case (state)
        FILL: begin
          if (col == COL_FILL_END) begin
            state_nxt = SLIDE;
            phase_nxt = '0;
          end
        end
        SLIDE: begin
          emit_c    = (phase == '0);
          phase_nxt = (phase == PH_LAST) ? '0 : phase + PH_W'(1);
          // End of row: trailing columns are dropped and the next row refills.
          if (last_c) begin
            state_nxt = START_STATE;
            phase_nxt = '0;
          end
        end
        default: state_nxt = START_STATE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= START_STATE;
      col   <= '0;
      phase <= '0;
      sr    <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      phase <= phase_nxt;
      sr    <= sr_nxt;
    end
  end

  // Output registers; data_out holds the last window between emissions and across clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      row_done  <= 1'b0;
      data_out  <= '0;
    end else begin
      valid_out <= emit_c;
      row_done  <= last_c;
      if (emit_c) begin
        data_out <= sr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_pe_pooling_window_gen.sv
// Scoreboard bench for pe_pooling_window_gen over three window/stride/row configurations.
module tb_pe_pooling_window_gen;

  typedef struct {
    logic        win;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        vi  [3];
  logic        cl  [3];
  logic [7:0]  di  [3];
  logic        vo  [3];
  logic        rdn [3];
  logic [23:0] do_a;
  logic [23:0] do_b;
  logic [15:0] do_c;

  int          checks;
  int          errors;
  exp_t        sbq[$];
  int          col      [3];
  int          hist     [3][16];
  logic [31:0] last_win [3];
  int          mn [3] = '{3, 3, 2};
  int          ms [3] = '{2, 1, 2};
  int          ml [3] = '{16, 16, 6};

  pe_pooling_window_gen #(.pDATA_WIDTH(8), .pWINDOW_SIZE(3), .pSTRIDE(2), .pROW_LEN(16)) u_a (
    .clk(clk), .rst(rst), .clear(cl[0]), .valid_in(vi[0]), .data_in(di[0]),
    .valid_out(vo[0]), .data_out(do_a), .row_done(rdn[0]));

  pe_pooling_window_gen #(.pDATA_WIDTH(8), .pWINDOW_SIZE(3), .pSTRIDE(1), .pROW_LEN(16)) u_b (
    .clk(clk), .rst(rst), .clear(cl[1]), .valid_in(vi[1]), .data_in(di[1]),
    .valid_out(vo[1]), .data_out(do_b), .row_done(rdn[1]));

  pe_pooling_window_gen #(.pDATA_WIDTH(8), .pWINDOW_SIZE(2), .pSTRIDE(2), .pROW_LEN(6)) u_c (
    .clk(clk), .rst(rst), .clear(cl[2]), .valid_in(vi[2]), .data_in(di[2]),
    .valid_out(vo[2]), .data_out(do_c), .row_done(rdn[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dout_of(input int id);
    case (id)
      0:       return 32'(do_a);
      1:       return 32'(do_b);
      default: return 32'(do_c);
    endcase
  endfunction

  // One clock: drive instance id, push expected events, then sample #1 after the edge.
  task automatic cycle(input int id, input logic v, input logic clr, input logic [7:0] d);
    exp_t        e;
    exp_t        p;
    logic        got_v;
    logic        got_rd;
    logic [31:0] got_d;
    int          c;
    e.win  = 1'b0;
    e.rd   = 1'b0;
    e.data = '0;
    for (int i = 0; i < 3; i++) begin
      vi[i] = 1'b0;
      cl[i] = 1'b0;
      di[i] = 8'($urandom);
    end
    vi[id] = v;
    cl[id] = clr;
    di[id] = d;
    if (clr) begin
      col[id] = 0;
    end else if (v) begin
      c = col[id];
      hist[id][c] = int'(d);
      e.rd = (c == ml[id] - 1);
      if (c >= mn[id] - 1 && ((c - mn[id] + 1) % ms[id]) == 0) begin
        e.win = 1'b1;
        for (int k = 0; k < mn[id]; k++) e.data[k*8 +: 8] = 8'(hist[id][c - mn[id] + 1 + k]);
      end
      if (e.win || e.rd) sbq.push_back(e);
      col[id] = (c + 1) % ml[id];
    end
    @(posedge clk);
    #1;
    got_v  = vo[id];
    got_rd = rdn[id];
    got_d  = dout_of(id);
    chk("valid_out", 32'(got_v), 32'(e.win));
    chk("row_done", 32'(got_rd), 32'(e.rd));
    if (got_v || got_rd) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 32'(sbq.size()), 32'd1);
      end else begin
        p = sbq.pop_front();
        if (p.win) begin
          chk("window", got_d, p.data);
          last_win[id] = p.data;
        end
      end
    end else begin
      chk("data_hold", got_d, last_win[id]);
    end
  endtask

  task automatic feed_row(input int id, input int base);
    for (int i = 0; i < ml[id]; i++) cycle(id, 1'b1, 1'b0, 8'(base + i));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      col[i]      = 0;
      last_win[i] = '0;
    end
    sbq.delete();
  endtask

  initial begin
    int idx;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vi[i] = 1'b0;
      cl[i] = 1'b0;
      di[i] = '0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid_out", 32'(vo[0]), 32'd0);
    chk("reset_row_done", 32'(rdn[0]), 32'd0);
    chk("reset_data_out", 32'(do_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back row, N=3 S=2 L=16.
    feed_row(0, 0);

    // Same row with random input bubbles.
    idx = 0;
    for (int n = 0; n < 200 && idx < 16; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        cycle(0, 1'b1, 1'b0, 8'(idx));
        idx++;
      end else begin
        cycle(0, 1'b0, 1'b0, 8'hEE);
      end
    end
    while (idx < 16) begin
      cycle(0, 1'b1, 1'b0, 8'(idx));
      idx++;
    end

    // Clear with a coincident sample after column 7.
    for (int i = 0; i < 8; i++) cycle(0, 1'b1, 1'b0, 8'(i));
    cycle(0, 1'b1, 1'b1, 8'd8);
    chk("clear_hold", 32'(do_a), 32'h0006_0504);
    cycle(0, 1'b1, 1'b0, 8'd50);
    cycle(0, 1'b1, 1'b0, 8'd51);
    cycle(0, 1'b1, 1'b0, 8'd52);

    // Asynchronous reset between edges while a window is on the outputs.
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid_out", 32'(vo[0]), 32'd0);
    chk("async_rst_row_done", 32'(rdn[0]), 32'd0);
    chk("async_rst_data_out", 32'(do_a), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    feed_row(0, 0);

    // N=3 S=1: two rows back-to-back, windows never straddle the row boundary.
    feed_row(1, 0);
    feed_row(1, 100);

    // N=2 S=2 L=6: last window coincides with row_done.
    feed_row(2, 1);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
